seq_control_unit: RTL and testbench

Multi-cycle, parametrised successor to the 16-bit CPU's combinational instruction decoder. It owns the program counter, fetches each instruction over a req/ack port, and decodes it into ALU, register-file and RAM control. It sequences every instruction through an explicit FSM and tolerates wait states on instruction and data memory. It adds conditional branching on a latched zero flag, immediate load, compare and halt. It sits between instruction memory, the register file, the ALU and data RAM.

---
 rtl/cpu_ctrl_pkg.sv | 37 +++
 rtl/instr_decoder.sv | 49 ++++
 rtl/seq_control_unit.sv | 197 +++++++++++++++++++
 tb/tb_seq_control_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the sequenced control unit: opcode map, FSM state
// encoding and register-file write-back source codes.
package cpu_ctrl_pkg;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_AND   = 2;
  localparam int unsigned OP_OR    = 3;
  localparam int unsigned OP_XOR   = 4;
  localparam int unsigned OP_NOT   = 5;
  localparam int unsigned OP_SHL   = 6;
  localparam int unsigned OP_SHR   = 7;
  localparam int unsigned OP_JMP   = 8;
  localparam int unsigned OP_JZ    = 9;
  localparam int unsigned OP_LOAD  = 10;
  localparam int unsigned OP_STORE = 11;
  localparam int unsigned OP_LDI   = 12;
  localparam int unsigned OP_CMP   = 13;
  localparam int unsigned OP_NOP   = 14;
  localparam int unsigned OP_HALT  = 15;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_RAM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder
// Combinational split of an instruction word into its fields plus one-hot
// style opcode class flags.
// Ports:
//   ir       in  INSTR_W     instruction word
//   opc      out OPC_W       opcode field (MSBs)
//   reg1     out REG_ADDR_W  destination / first source select
//   reg2     out REG_ADDR_W  second source select
//   imm      out RAM_ADDR_W  address / immediate field (LSBs)
//   is_*     out 1           opcode class flags
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W      = 4,
  parameter int REG_ADDR_W = 2,
  parameter int RAM_ADDR_W = 8,
  parameter int INSTR_W    = 16
) (
  input  logic [INSTR_W-1:0]    ir,
  output logic [OPC_W-1:0]      opc,
  output logic [REG_ADDR_W-1:0] reg1,
  output logic [REG_ADDR_W-1:0] reg2,
  output logic [RAM_ADDR_W-1:0] imm,
  output logic                  is_alu,
  output logic                  is_jmp,
  output logic                  is_jz,
  output logic                  is_ld,
  output logic                  is_st,
  output logic                  is_ldi,
  output logic                  is_cmp,
  output logic                  is_halt
);

  assign opc  = ir[INSTR_W-1 -: OPC_W];
  assign reg1 = ir[INSTR_W-OPC_W-1 -: REG_ADDR_W];
  assign reg2 = ir[INSTR_W-OPC_W-REG_ADDR_W-1 -: REG_ADDR_W];
  assign imm  = ir[RAM_ADDR_W-1:0];

  // Opcodes below JMP form the ALU class.
  assign is_alu  = (opc <  OPC_W'(OP_JMP));
  assign is_jmp  = (opc == OPC_W'(OP_JMP));
  assign is_jz   = (opc == OPC_W'(OP_JZ));
  assign is_ld   = (opc == OPC_W'(OP_LOAD));
  assign is_st   = (opc == OPC_W'(OP_STORE));
  assign is_ldi  = (opc == OPC_W'(OP_LDI));
  assign is_cmp  = (opc == OPC_W'(OP_CMP));
  assign is_halt = (opc == OPC_W'(OP_HALT));

endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit
// Multi-cycle instruction sequencer: owns the PC, fetches over a req/ack
// port, decodes and drives ALU, register-file and data-RAM control.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/adr/ack/data      instruction fetch port (adr = pc)
//   alu_code, alu_zero         ALU operation select / zero result
//   reg1, reg2, reg_read,
//   reg_write, wb_sel, imm     register-file control and immediate
//   ram_req/we/adr/ack         data RAM port
//   pc_jump, pc, halted        PC status
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_RST   | reset state, all requests low, leaves next cycle
// ST_FETCH | imem_req high until imem_ack; latch IR, pc+1
// ST_DECODE| register-file read
// ST_EXEC  | flag update, jump resolution, dispatch by opcode
// ST_MEM   | data RAM access held until ram_ack
// ST_WB    | single-cycle register write-back
// ST_HALT  | absorbing, reset only exit
module seq_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W      = 4,
  parameter int REG_ADDR_W = 2,
  parameter int RAM_ADDR_W = 8,
  parameter int INSTR_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [RAM_ADDR_W-1:0] imem_adr,
  input  logic                  imem_ack,
  input  logic [INSTR_W-1:0]    imem_data,
  output logic [OPC_W-1:0]      alu_code,
  input  logic                  alu_zero,
  output logic [REG_ADDR_W-1:0] reg1,
  output logic [REG_ADDR_W-1:0] reg2,
  output logic                  reg_read,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic [RAM_ADDR_W-1:0] imm,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_adr,
  input  logic                  ram_ack,
  output logic                  pc_jump,
  output logic [RAM_ADDR_W-1:0] pc,
  output logic                  halted
);

  state_t                state_q, state_nxt;
  logic [INSTR_W-1:0]    ir_q, ir_nxt;
  logic [RAM_ADDR_W-1:0] pc_nxt;
  logic                  zflag_q, zflag_nxt;

  logic [OPC_W-1:0]      d_opc;
  logic [REG_ADDR_W-1:0] d_reg1, d_reg2;
  logic [RAM_ADDR_W-1:0] d_imm;
  logic d_is_alu, d_is_jmp, d_is_jz, d_is_ld, d_is_st, d_is_ldi, d_is_cmp, d_is_halt;

  logic                  fields_on;
  logic                  imem_req_d, reg_read_d, reg_write_d, ram_req_d, ram_we_d;
  logic                  pc_jump_d, halted_d;
  logic [OPC_W-1:0]      alu_code_d;
  logic [REG_ADDR_W-1:0] reg1_d, reg2_d;
  logic [RAM_ADDR_W-1:0] imm_d, ram_adr_d;
  logic [1:0]            wb_sel_d;

  // IR only changes on a fetch ack; decoding the next IR lets the outputs
  // for the coming state be registered while still reflecting the new word.
  always_comb begin
    ir_nxt = ir_q;
    if (state_q == ST_FETCH && imem_ack) ir_nxt = imem_data;
  end

  instr_decoder #(
    .OPC_W      (OPC_W),
    .REG_ADDR_W (REG_ADDR_W),
    .RAM_ADDR_W (RAM_ADDR_W),
    .INSTR_W    (INSTR_W)
  ) u_dec (
    .ir      (ir_nxt),
    .opc     (d_opc),
    .reg1    (d_reg1),
    .reg2    (d_reg2),
    .imm     (d_imm),
    .is_alu  (d_is_alu),
    .is_jmp  (d_is_jmp),
    .is_jz   (d_is_jz),
    .is_ld   (d_is_ld),
    .is_st   (d_is_st),
    .is_ldi  (d_is_ldi),
    .is_cmp  (d_is_cmp),
    .is_halt (d_is_halt)
  );

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc;
    zflag_nxt = zflag_q;
    unique case (state_q)
      ST_RST:    state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          pc_nxt    = pc + RAM_ADDR_W'(1);
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (d_is_alu || d_is_cmp) zflag_nxt = alu_zero;
        if (d_is_alu || d_is_ldi)     state_nxt = ST_WB;
        else if (d_is_ld || d_is_st)  state_nxt = ST_MEM;
        else if (d_is_halt)           state_nxt = ST_HALT;
        else begin
          state_nxt = ST_FETCH;
          if (d_is_jmp || (d_is_jz && zflag_q)) pc_nxt = d_imm;
        end
      end
      ST_MEM: begin
        if (ram_ack) state_nxt = d_is_ld ? ST_WB : ST_FETCH;
      end
      ST_WB:     state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_RST;
    endcase
  end

  // Moore outputs evaluated for the state being entered, then registered.
  always_comb begin
    fields_on   = state_nxt inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
    imem_req_d  = (state_nxt == ST_FETCH);
    reg_read_d  = (state_nxt == ST_DECODE);
    reg_write_d = (state_nxt == ST_WB);
    ram_req_d   = (state_nxt == ST_MEM);
    ram_we_d    = ram_req_d && d_is_st;
    ram_adr_d   = ram_req_d ? d_imm : '0;
    halted_d    = (state_nxt == ST_HALT);
    // zflag is stable across DECODE->EXEC, so it resolves JZ here.
    pc_jump_d   = (state_nxt == ST_EXEC) && (d_is_jmp || (d_is_jz && zflag_q));
    reg1_d      = fields_on ? d_reg1 : '0;
    reg2_d      = fields_on ? d_reg2 : '0;
    imm_d       = fields_on ? d_imm  : '0;
    alu_code_d  = '0;
    if (fields_on && d_is_alu) alu_code_d = d_opc;
    // CMP is a subtraction whose result only feeds the zero flag.
    if (fields_on && d_is_cmp) alu_code_d = OPC_W'(OP_SUB);
    wb_sel_d    = WB_ALU;
    if (reg_write_d && d_is_ld)  wb_sel_d = WB_RAM;
    if (reg_write_d && d_is_ldi) wb_sel_d = WB_IMM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      ir_q      <= '0;
      pc        <= '0;
      zflag_q   <= 1'b0;
      imem_req  <= 1'b0;
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_adr   <= '0;
      halted    <= 1'b0;
      pc_jump   <= 1'b0;
      reg1      <= '0;
      reg2      <= '0;
      imm       <= '0;
      alu_code  <= '0;
      wb_sel    <= WB_ALU;
    end else begin
      state_q   <= state_nxt;
      ir_q      <= ir_nxt;
      pc        <= pc_nxt;
      zflag_q   <= zflag_nxt;
      imem_req  <= imem_req_d;
      reg_read  <= reg_read_d;
      reg_write <= reg_write_d;
      ram_req   <= ram_req_d;
      ram_we    <= ram_we_d;
      ram_adr   <= ram_adr_d;
      halted    <= halted_d;
      pc_jump   <= pc_jump_d;
      reg1      <= reg1_d;
      reg2      <= reg2_d;
      imm       <= imm_d;
      alu_code  <= alu_code_d;
      wb_sel    <= wb_sel_d;
    end
  end

  assign imem_adr = pc;

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit
// Scoreboard bench: a program-level model walks instruction memory and
// queues the expected observable events (register read, write-back, jump,
// RAM request cycles, halt) with their cycle numbers; the run loop pops and
// compares each event as the DUT produces it.
module tb_seq_control_unit;

  localparam int EV_NONE = 0;
  localparam int EV_RD   = 1;
  localparam int EV_WB   = 2;
  localparam int EV_JMP  = 3;
  localparam int EV_MEM  = 4;
  localparam int EV_HALT = 5;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic        clk, rst_n;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_adr;
  logic [15:0] imem_data;
  logic [3:0]  alu_code;
  logic        alu_zero;
  logic [1:0]  reg1, reg2, wb_sel;
  logic        reg_read, reg_write;
  logic [7:0]  imm, ram_adr, pc;
  logic        ram_req, ram_we, ram_ack, pc_jump, halted;
  logic [63:0] outs;

  logic [15:0] imem [256];
  ev_t         evq [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          imem_wait = 0;
  int          ram_wait = 0;
  bit          imem_tie = 0;
  string       cur_name = "";

  seq_control_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_adr  (imem_adr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_code  (alu_code),
    .alu_zero  (alu_zero),
    .reg1      (reg1),
    .reg2      (reg2),
    .reg_read  (reg_read),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .imm       (imm),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_adr   (ram_adr),
    .ram_ack   (ram_ack),
    .pc_jump   (pc_jump),
    .pc        (pc),
    .halted    (halted)
  );

  assign outs = 64'({imem_req, imem_adr, alu_code, reg1, reg2, reg_read, reg_write,
                     wb_sel, imm, ram_req, ram_we, ram_adr, pc_jump, pc, halted});

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction and data memory responders with programmable wait states.
  initial begin
    int iw_cnt;
    int rw_cnt;
    iw_cnt    = 0;
    rw_cnt    = 0;
    imem_ack  = 1'b0;
    ram_ack   = 1'b0;
    imem_data = '0;
    forever begin
      @(negedge clk);
      if (imem_tie) imem_ack = 1'b1;
      else if (imem_req) begin
        if (iw_cnt >= imem_wait) begin imem_ack = 1'b1; iw_cnt = 0; end
        else begin imem_ack = 1'b0; iw_cnt++; end
      end else begin
        imem_ack = 1'b0;
        iw_cnt   = 0;
      end
      imem_data = imem[imem_adr];
      if (ram_req) begin
        if (rw_cnt >= ram_wait) begin ram_ack = 1'b1; rw_cnt = 0; end
        else begin ram_ack = 1'b0; rw_cnt++; end
      end else begin
        ram_ack = 1'b0;
        rw_cnt  = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic string ev_name(input int kind);
    case (kind)
      EV_RD:   return "reg_read";
      EV_WB:   return "write_back";
      EV_JMP:  return "pc_jump";
      EV_MEM:  return "ram_req";
      EV_HALT: return "halted";
      default: return "none";
    endcase
  endfunction

  task automatic push(input int kind, input int cyc, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.val  = val;
    evq.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int cyc, input logic [31:0] val);
    ev_t e;
    if (evq.size() == 0) begin
      e.kind = EV_NONE;
      e.cyc  = 0;
      e.val  = '0;
    end else e = evq.pop_front();
    check_val({cur_name, ":", ev_name(kind)}, {8'(kind), 24'(cyc), val},
              {8'(e.kind), 24'(e.cyc), e.val});
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 256; a++) imem[a] = 16'hF000;
  endtask

  // Program-level model: per-instruction latency from the opcode plus wait
  // states; cycle 1 is the first FETCH cycle after reset release.
  task automatic build_expect(input bit az, input int w, input int m);
    logic [7:0]  mpc;
    logic [15:0] ins;
    logic [3:0]  op;
    logic [1:0]  r1, r2;
    logic [7:0]  im;
    bit          zf, done;
    int          s, s_ex;
    mpc = '0; zf = 0; done = 0; s = 1;
    for (int k = 0; k < 64 && !done; k++) begin
      ins = imem[mpc];
      op = ins[15:12]; r1 = ins[11:10]; r2 = ins[9:8]; im = ins[7:0];
      mpc  = mpc + 8'd1;
      s_ex = s + w + 2;
      push(EV_RD, s_ex - 1, 32'({r1, r2}));
      if (op < 4'd8) begin
        push(EV_WB, s_ex + 1, 32'({mpc, r1, r2, 2'b00, op, im}));
        zf = az;
        s  = s_ex + 2;
      end else begin
        case (op)
          4'h8, 4'h9: begin
            if (op == 4'h8 || zf) begin
              push(EV_JMP, s_ex, 32'({mpc, im}));
              mpc = im;
            end
            s = s_ex + 1;
          end
          4'hA: begin
            for (int j = 0; j <= m; j++) push(EV_MEM, s_ex + 1 + j, 32'({1'b0, im}));
            push(EV_WB, s_ex + 2 + m, 32'({mpc, r1, r2, 2'b01, 4'h0, im}));
            s = s_ex + 3 + m;
          end
          4'hB: begin
            for (int j = 0; j <= m; j++) push(EV_MEM, s_ex + 1 + j, 32'({1'b1, im}));
            s = s_ex + 2 + m;
          end
          4'hC: begin
            push(EV_WB, s_ex + 1, 32'({mpc, r1, r2, 2'b10, 4'h0, im}));
            s = s_ex + 2;
          end
          4'hD: begin zf = az; s = s_ex + 1; end
          4'hE: s = s_ex + 1;
          default: begin
            push(EV_HALT, s_ex + 1, 32'(mpc));
            done = 1;
          end
        endcase
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input string name, input bit az, input int iw, input int rw, input bit tie);
    int   cyc, drain;
    bit   hprev;
    logic [7:0] halt_pc;
    cur_name  = name;
    alu_zero  = az;
    imem_wait = iw;
    ram_wait  = rw;
    imem_tie  = tie;
    evq.delete();
    build_expect(az, iw, rw);
    halt_pc = evq[evq.size() - 1].val[7:0];
    cyc = 0; drain = 0; hprev = 0;
    do_reset();
    while ((evq.size() != 0 || drain < 8) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (evq.size() == 0) drain++;
      if (reg_read)          sb_pop(EV_RD, cyc, 32'({reg1, reg2}));
      if (reg_write)         sb_pop(EV_WB, cyc, 32'({pc, reg1, reg2, wb_sel, alu_code, imm}));
      if (pc_jump)           sb_pop(EV_JMP, cyc, 32'({pc, imm}));
      if (ram_req)           sb_pop(EV_MEM, cyc, 32'({ram_we, ram_adr}));
      if (halted && !hprev)  sb_pop(EV_HALT, cyc, 32'(pc));
      hprev = halted;
    end
    check_val({name, ":events_left"}, 64'(evq.size()), 64'd0);
    check_val({name, ":halt_hold"}, {halted, imem_req, ram_req, pc}, {1'b1, 1'b0, 1'b0, halt_pc});
    imem_tie = 0;
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    alu_zero = 1'b0;
    clear_imem();
    #12;
    check_val("reset:outputs", outs, 64'd0);

    // XOR r2,r0 with the fetch ack tied high, including in RST and HALT.
    clear_imem();
    imem[0] = 16'h4800;
    run_prog("xor_tied", 1'b0, 0, 0, 1'b1);

    // Unconditional jump, then LDI at the target, with fetch wait states.
    clear_imem();
    imem[0] = 16'h8004;
    imem[4] = 16'hC1AB;
    run_prog("jmp_ldi", 1'b0, 2, 0, 1'b0);

    // CMP then JZ 0x10, taken and not taken.
    clear_imem();
    imem[0] = 16'hD000;
    imem[1] = 16'h9010;
    run_prog("jz_taken", 1'b1, 0, 0, 1'b0);
    run_prog("jz_not_taken", 1'b0, 0, 0, 1'b0);

    // LOAD with 3-cycle RAM request, STORE, ALU op setting zflag, JZ.
    clear_imem();
    imem[0]    = 16'hA305;
    imem[1]    = 16'hB2F0;
    imem[2]    = 16'h1600;
    imem[3]    = 16'h9020;
    run_prog("load_store", 1'b1, 0, 2, 1'b0);

    // PC wrap: NOP at 0xFF falls through to 0x00, whose JZ is now taken.
    clear_imem();
    imem[8'h00] = 16'h90FE;
    imem[8'h01] = 16'hD000;
    imem[8'h02] = 16'h90FF;
    imem[8'hFF] = 16'hE000;
    run_prog("pc_wrap", 1'b1, 1, 0, 1'b0);

    // Reset asserted in the middle of a STORE's RAM access.
    cur_name = "rst_mid_mem";
    clear_imem();
    imem[0]   = 16'hB2F0;
    ram_wait  = 20;
    imem_wait = 0;
    do_reset();
    n = 0;
    while (!ram_req && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    check_val("rst_mid_mem:in_mem", {ram_req, ram_we, ram_adr}, {1'b1, 1'b1, 8'hF0});
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_mem:drop", outs, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_mid_mem:rst_state", {imem_req, imem_adr}, 9'h000);
    @(negedge clk);
    check_val("rst_mid_mem:fetch", {imem_req, imem_adr, ram_req}, {1'b1, 8'h00, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
